vga_timing_gen: RTL and testbench

// - Parametrised H+V VGA raster timing generator; successor to the line-only hsync generator.
// - Produces hsync/vsync, display-enable, scaled pixel coordinates and line/frame strobes.
// - Feeds the framebuffer read-address logic and the colour output stage.

---
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// H+V VGA raster timing generator. A raster position (v_cnt, h_cnt) advances
// on every enabled edge. The outputs register the decode of the position
// before it advances, so they lag the position by one cycle. Logical pixel
// coordinates come from small sub-counters rather than dividers.
module vga_timing_gen #(
  parameter int H_SYNC   = 192,
  parameter int H_BP     = 96,
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 32,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int H_DIV    = 10,
  parameter int V_DIV    = 5,
  parameter int HPIX_W   = 7,
  parameter int VPIX_W   = 7,
  parameter int SYNC_POL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic [HPIX_W-1:0] hpixel,
  output logic [VPIX_W-1:0] vpixel,
  output logic              line_end,
  output logic              frame_end
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int HSW = (H_DIV > 1) ? $clog2(H_DIV) : 1;
  localparam int VSW = (V_DIV > 1) ? $clog2(V_DIV) : 1;

  localparam logic            SP        = (SYNC_POL != 0);
  localparam logic [HW-1:0]   H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]   H_SYNC_C  = HW'(H_SYNC);
  localparam logic [HW-1:0]   H_START_C = HW'(H_START);
  localparam logic [HW-1:0]   H_END_C   = HW'(H_START + H_ACTIVE);
  localparam logic [VW-1:0]   V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]   V_SYNC_C  = VW'(V_SYNC);
  localparam logic [VW-1:0]   V_START_C = VW'(V_START);
  localparam logic [VW-1:0]   V_END_C   = VW'(V_START + V_ACTIVE);
  localparam logic [HSW-1:0]  H_SUB_LAST = HSW'(H_DIV - 1);
  localparam logic [VSW-1:0]  V_SUB_LAST = VSW'(V_DIV - 1);

  logic [HW-1:0]     h_cnt, h_nxt;
  logic [VW-1:0]     v_cnt, v_nxt;
  logic [HSW-1:0]    h_sub;
  logic [VSW-1:0]    v_sub;
  logic [HPIX_W-1:0] h_pix;
  logic [VPIX_W-1:0] v_pix;
  logic              h_wrap, h_in, v_in;

  // Decode of the current raster position and its successor.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
    v_nxt  = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    h_in   = (h_cnt >= H_START_C) && (h_cnt < H_END_C);
    v_in   = (v_cnt >= V_START_C) && (v_cnt < V_END_C);
  end

  // Raster position: h wraps every line, v steps on the last cycle of a line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      h_cnt <= h_nxt;
      if (h_wrap) v_cnt <= v_nxt;
    end
  end

  // Column tracker: zeroed as the position enters the active span, then
  // counts H_DIV cycles per column. The step past the last column may wrap
  // h_pix, but it is masked by h_in before reaching hpixel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_sub <= '0;
      h_pix <= '0;
    end else if (en) begin
      if (h_nxt == H_START_C) begin
        h_sub <= '0;
        h_pix <= '0;
      end else if (h_in) begin
        if (h_sub == H_SUB_LAST) begin
          h_sub <= '0;
          h_pix <= h_pix + 1'b1;
        end else begin
          h_sub <= h_sub + 1'b1;
        end
      end
    end
  end

  // Row tracker: same scheme as the column tracker, stepping once per line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_sub <= '0;
      v_pix <= '0;
    end else if (en && h_wrap) begin
      if (v_nxt == V_START_C) begin
        v_sub <= '0;
        v_pix <= '0;
      end else if (v_in) begin
        if (v_sub == V_SUB_LAST) begin
          v_sub <= '0;
          v_pix <= v_pix + 1'b1;
        end else begin
          v_sub <= v_sub + 1'b1;
        end
      end
    end
  end

  // Registered outputs: decode of the pre-advance position; held while en is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync     <= ~SP;
      vsync     <= ~SP;
      active    <= 1'b0;
      hpixel    <= '0;
      vpixel    <= '0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else if (en) begin
      hsync     <= (h_cnt < H_SYNC_C) ? SP : ~SP;
      vsync     <= (v_cnt < V_SYNC_C) ? SP : ~SP;
      active    <= h_in && v_in;
      hpixel    <= h_in ? h_pix : '0;
      vpixel    <= v_in ? v_pix : '0;
      line_end  <= h_wrap;
      frame_end <= h_wrap && (v_cnt == V_LAST);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-parameter instance and a tiny
// instance (active-high syncs). Expected values come from hand tables and
// from an arithmetic reference model of the raster.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, en_d, rst_s, en_s;
  logic hs_d, vs_d, act_d, le_d, fe_d;
  logic [6:0] hp_d, vp_d;
  logic hs_s, vs_s, act_s, le_s, fe_s;
  logic [1:0] hp_s, vp_s;

  vga_timing_gen u_d (
    .clk(clk), .reset(rst_d), .en(en_d),
    .hsync(hs_d), .vsync(vs_d), .active(act_d),
    .hpixel(hp_d), .vpixel(vp_d), .line_end(le_d), .frame_end(fe_d)
  );

  vga_timing_gen #(
    .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_FP(1),
    .H_DIV(2), .V_DIV(1), .HPIX_W(2), .VPIX_W(2), .SYNC_POL(1)
  ) u_s (
    .clk(clk), .reset(rst_s), .en(en_s),
    .hsync(hs_s), .vsync(vs_s), .active(act_s),
    .hpixel(hp_s), .vpixel(vp_s), .line_end(le_s), .frame_end(fe_s)
  );

  typedef struct packed {
    logic        hs, vs, act;
    logic [15:0] hp, vp;
    logic        le, fe;
  } out_t;

  typedef struct {
    int hsy, hbp, hact, hfp, vsy, vbp, vact, vfp, hdiv, vdiv;
    bit sp;
  } cfg_t;

  typedef struct { int v, h; out_t o; } mdl_t;
  typedef struct { bit rst_n, en; out_t exp; } svec_t;
  typedef struct { int v, h; out_t exp; } dvec_t;

  int total = 0;
  int bad   = 0;

  function automatic out_t o(int hs, int vs, int act, int hp, int vp, int le, int fe);
    out_t r;
    r.hs = hs[0]; r.vs = vs[0]; r.act = act[0];
    r.hp = 16'(hp); r.vp = 16'(vp);
    r.le = le[0]; r.fe = fe[0];
    return r;
  endfunction

  function automatic out_t out_d();
    return '{hs_d, vs_d, act_d, {9'b0, hp_d}, {9'b0, vp_d}, le_d, fe_d};
  endfunction

  function automatic out_t out_s();
    return '{hs_s, vs_s, act_s, {14'b0, hp_s}, {14'b0, vp_s}, le_s, fe_s};
  endfunction

  // Reference: what the raster should show at position (v, h).
  function automatic out_t decode(cfg_t c, int v, int h);
    int hst, vst;
    bit hin, vin;
    out_t r;
    hst = c.hsy + c.hbp;
    vst = c.vsy + c.vbp;
    hin = (h >= hst) && (h < hst + c.hact);
    vin = (v >= vst) && (v < vst + c.vact);
    r.hs  = (h < c.hsy) ? c.sp : !c.sp;
    r.vs  = (v < c.vsy) ? c.sp : !c.sp;
    r.act = hin && vin;
    r.hp  = hin ? 16'((h - hst) / c.hdiv) : 16'd0;
    r.vp  = vin ? 16'((v - vst) / c.vdiv) : 16'd0;
    r.le  = (h == c.hsy + c.hbp + c.hact + c.hfp - 1);
    r.fe  = r.le && (v == c.vsy + c.vbp + c.vact + c.vfp - 1);
    return r;
  endfunction

  // Reference: one clock edge of the generator.
  function automatic mdl_t mnext(cfg_t c, mdl_t m, bit rst_n, bit en);
    mdl_t r;
    r = m;
    if (!rst_n) begin
      r.v = 0; r.h = 0;
      r.o = o(!c.sp, !c.sp, 0, 0, 0, 0, 0);
    end else if (en) begin
      r.o = decode(c, m.v, m.h);
      r.h = m.h + 1;
      if (r.h == c.hsy + c.hbp + c.hact + c.hfp) begin
        r.h = 0;
        r.v = m.v + 1;
        if (r.v == c.vsy + c.vbp + c.vact + c.vfp) r.v = 0;
      end
    end
    return r;
  endfunction

  task automatic chk(string nm, out_t a, out_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got hs=%0b vs=%0b act=%0b hp=%0d vp=%0d le=%0b fe=%0b, want hs=%0b vs=%0b act=%0b hp=%0d vp=%0d le=%0b fe=%0b",
               nm, a.hs, a.vs, a.act, a.hp, a.vp, a.le, a.fe,
               e.hs, e.vs, e.act, e.hp, e.vp, e.le, e.fe);
    end
  endtask

  task automatic chk_int(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  cfg_t  cd, cs;
  mdl_t  md, ms;
  svec_t stbl[15];
  dvec_t dtbl[17];

  initial begin
    int edges, le_cnt, hs_cnt, fe_cnt, tgt;

    cd = '{192, 96, 1280, 32, 2, 29, 480, 10, 10, 5, 1'b0};
    cs = '{2, 1, 4, 1, 1, 1, 2, 1, 2, 1, 1'b1};
    md = '{0, 0, o(1, 1, 0, 0, 0, 0, 0)};
    ms = '{0, 0, o(0, 0, 0, 0, 0, 0, 0)};

    // Small config, per-edge vectors: {reset, en} -> outputs after the edge.
    stbl[0]  = '{1'b0, 1'b1, o(0, 0, 0, 0, 0, 0, 0)};  // reset
    stbl[1]  = '{1'b1, 1'b1, o(1, 1, 0, 0, 0, 0, 0)};  // P(0,0)
    stbl[2]  = '{1'b1, 1'b0, o(1, 1, 0, 0, 0, 0, 0)};  // hold
    stbl[3]  = '{1'b1, 1'b1, o(1, 1, 0, 0, 0, 0, 0)};  // P(0,1)
    stbl[4]  = '{1'b1, 1'b1, o(0, 1, 0, 0, 0, 0, 0)};  // P(0,2)
    stbl[5]  = '{1'b1, 1'b1, o(0, 1, 0, 0, 0, 0, 0)};  // P(0,3)
    stbl[6]  = '{1'b1, 1'b1, o(0, 1, 0, 0, 0, 0, 0)};  // P(0,4)
    stbl[7]  = '{1'b1, 1'b1, o(0, 1, 0, 1, 0, 0, 0)};  // P(0,5)
    stbl[8]  = '{1'b1, 1'b0, o(0, 1, 0, 1, 0, 0, 0)};  // hold
    stbl[9]  = '{1'b1, 1'b1, o(0, 1, 0, 1, 0, 0, 0)};  // P(0,6)
    stbl[10] = '{1'b1, 1'b1, o(0, 1, 0, 0, 0, 1, 0)};  // P(0,7)
    stbl[11] = '{1'b1, 1'b0, o(0, 1, 0, 0, 0, 1, 0)};  // strobe held
    stbl[12] = '{1'b1, 1'b1, o(1, 0, 0, 0, 0, 0, 0)};  // P(1,0)
    stbl[13] = '{1'b0, 1'b1, o(0, 0, 0, 0, 0, 0, 0)};  // mid-line reset
    stbl[14] = '{1'b1, 1'b1, o(1, 1, 0, 0, 0, 0, 0)};  // P(0,0) again

    // Default config checkpoints: output for P(v,h) after v*1600+h+1 edges.
    dtbl[0]  = '{0,  0,    o(0, 0, 0, 0,   0, 0, 0)};
    dtbl[1]  = '{0,  191,  o(0, 0, 0, 0,   0, 0, 0)};
    dtbl[2]  = '{0,  192,  o(1, 0, 0, 0,   0, 0, 0)};
    dtbl[3]  = '{0,  1599, o(1, 0, 0, 0,   0, 1, 0)};
    dtbl[4]  = '{1,  0,    o(0, 0, 0, 0,   0, 0, 0)};
    dtbl[5]  = '{2,  0,    o(0, 1, 0, 0,   0, 0, 0)};
    dtbl[6]  = '{30, 1000, o(1, 1, 0, 71,  0, 0, 0)};
    dtbl[7]  = '{31, 287,  o(1, 1, 0, 0,   0, 0, 0)};
    dtbl[8]  = '{31, 288,  o(1, 1, 1, 0,   0, 0, 0)};
    dtbl[9]  = '{31, 297,  o(1, 1, 1, 0,   0, 0, 0)};
    dtbl[10] = '{31, 298,  o(1, 1, 1, 1,   0, 0, 0)};
    dtbl[11] = '{31, 1567, o(1, 1, 1, 127, 0, 0, 0)};
    dtbl[12] = '{31, 1568, o(1, 1, 0, 0,   0, 0, 0)};
    dtbl[13] = '{35, 1000, o(1, 1, 1, 71,  0, 0, 0)};
    dtbl[14] = '{36, 200,  o(1, 1, 0, 0,   1, 0, 0)};
    dtbl[15] = '{36, 288,  o(1, 1, 1, 0,   1, 0, 0)};
    dtbl[16] = '{36, 500,  o(1, 1, 1, 21,  1, 0, 0)};

    // Reset both instances.
    rst_d = 1'b0; en_d = 1'b1; rst_s = 1'b0; en_s = 1'b1;
    tick();
    tick();
    chk("rst_s", out_s(), o(0, 0, 0, 0, 0, 0, 0));
    chk("rst_d", out_d(), o(1, 1, 0, 0, 0, 0, 0));

    // Small config: vector table.
    for (int i = 0; i < 15; i++) begin
      rst_s = stbl[i].rst_n;
      en_s  = stbl[i].en;
      tick();
      ms = mnext(cs, ms, rst_s, en_s);
      chk($sformatf("s_tbl%0d", i), out_s(), stbl[i].exp);
    end

    // Small config: two full frames, continuous enable.
    rst_s = 1'b1; en_s = 1'b1;
    le_cnt = 0; fe_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      ms = mnext(cs, ms, 1'b1, 1'b1);
      chk("s_frame", out_s(), ms.o);
      if (le_s) le_cnt++;
      if (fe_s) fe_cnt++;
    end
    chk_int("s_line_end_cnt", le_cnt, 10);
    chk_int("s_frame_end_cnt", fe_cnt, 2);

    // Small config: random enable (~30% low) and rare resets against the model.
    for (int i = 0; i < 800; i++) begin
      en_s  = ($urandom_range(0, 9) >= 3);
      rst_s = ($urandom_range(0, 199) != 0);
      tick();
      ms = mnext(cs, ms, rst_s, en_s);
      chk("s_rand", out_s(), ms.o);
    end
    rst_s = 1'b1; en_s = 1'b0;

    // Default config: run from reset past the first active rows.
    rst_d = 1'b0; en_d = 1'b1;
    tick();
    md = mnext(cd, md, 1'b0, 1'b1);
    chk("d_rst2", out_d(), o(1, 1, 0, 0, 0, 0, 0));
    rst_d = 1'b1;
    edges = 0; le_cnt = 0; hs_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      tgt = dtbl[i].v * 1600 + dtbl[i].h + 1;
      while (edges < tgt) begin
        tick();
        edges++;
        md = mnext(cd, md, 1'b1, 1'b1);
        chk("d_model", out_d(), md.o);
        if (le_d) le_cnt++;
        if (!hs_d) hs_cnt++;
      end
      chk($sformatf("d_tbl_%0d_%0d", dtbl[i].v, dtbl[i].h), out_d(), dtbl[i].exp);
    end
    // Lines 0..35 complete, line 36 up to h=500.
    chk_int("d_line_end_cnt", le_cnt, 36);
    chk_int("d_hsync_low_cnt", hs_cnt, 37 * 192);

    // Default config: enable low holds everything.
    en_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d_hold", out_d(), o(1, 1, 1, 21, 1, 0, 0));
    end

    // Default config: reset in the middle of an active pixel, then restart at (0,0).
    en_d = 1'b1; rst_d = 1'b0;
    tick();
    md = mnext(cd, md, 1'b0, 1'b1);
    chk("d_midrst", out_d(), o(1, 1, 0, 0, 0, 0, 0));
    rst_d = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      md = mnext(cd, md, 1'b1, 1'b1);
      chk("d_restart", out_d(), md.o);
      if (i < 192) chk("d_restart_hs", out_d(), o(0, 0, 0, 0, 0, 0, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
